// File: rtl/fft_iter_sample_loader.sv
// Input-side loader for the 32-point iterative FFT core.
// Pairs consecutive stream samples into dual-port RAM writes, kicks the core
// with START once a frame is loaded, and holds off the stream while the core
// owns its input RAM.
module fft_iter_sample_loader #(
  parameter int IWL         = 32,
  parameter int AWL         = 5,
  parameter int BIT_REV     = 1,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic           EN,
  input  logic [IWL-1:0] i_DATA,
  input  logic           i_VALID,
  output logic           o_READY,
  output logic [IWL-1:0] o_A_DATA,
  output logic [IWL-1:0] o_B_DATA,
  output logic [IWL-1:0] o_A_ADDR,
  output logic [IWL-1:0] o_B_ADDR,
  output logic           o_RAM_Wr,
  output logic           o_START,
  input  logic           i_RAM_BLOCK,
  output logic           o_ERR
);

  localparam int TW = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [2:0] {
    FILL     = 3'd0,
    FLUSH    = 3'd1,
    KICK     = 3'd2,
    WAIT_ACK = 3'd3,
    WAIT_REL = 3'd4
  } state_t;

  state_t           state;
  logic [AWL-1:0]   count;
  logic [IWL-1:0]   hold;
  logic [TW-1:0]    tmo;
  logic             wr_pend;
  logic             start_pend;
  logic             err;
  logic [IWL-1:0]   a_data;
  logic [IWL-1:0]   b_data;
  logic [AWL-1:0]   a_addr;
  logic [AWL-1:0]   b_addr;

  logic             accept;
  logic             wr_fire;

  // Frame index to RAM address: optional bit reversal over AWL bits.
  function automatic logic [AWL-1:0] addr_of(input logic [AWL-1:0] k);
    logic [AWL-1:0] r;
    for (int i = 0; i < AWL; i++) r[i] = k[AWL-1-i];
    return (BIT_REV != 0) ? r : k;
  endfunction

  // Handshake and strobe gating; the strobes are registered flags masked by
  // EN and the RAM block so a pending write or START survives a stall.
  always_comb begin
    o_READY  = EN & ~i_RAM_BLOCK & (state == FILL);
    accept   = i_VALID & o_READY;
    wr_fire  = EN & ~i_RAM_BLOCK & wr_pend;
    o_RAM_Wr = wr_fire;
    o_START  = EN & start_pend;
  end

  assign o_A_DATA = a_data;
  assign o_B_DATA = b_data;
  assign o_A_ADDR = {{(IWL-AWL){1'b0}}, a_addr};
  assign o_B_ADDR = {{(IWL-AWL){1'b0}}, b_addr};
  assign o_ERR    = err;

  // Frame FSM: pairing, write hand-off, START issue and acknowledge timeout.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= FILL;
      count      <= '0;
      hold       <= '0;
      tmo        <= '0;
      wr_pend    <= 1'b0;
      start_pend <= 1'b0;
      err        <= 1'b0;
      a_data     <= '0;
      b_data     <= '0;
      a_addr     <= '0;
      b_addr     <= '0;
    end else if (EN) begin
      // NOTE: the clear is written before the FSM so that a write armed in the
      // same edge (last statement wins under non-blocking semantics) is kept.
      if (wr_fire) wr_pend <= 1'b0;
      start_pend <= 1'b0;

      case (state)
        FILL: begin
          if (accept) begin
            if (!count[0]) begin
              hold <= i_DATA;
            end else begin
              a_data  <= hold;
              b_data  <= i_DATA;
              a_addr  <= addr_of({count[AWL-1:1], 1'b0});
              b_addr  <= addr_of(count);
              wr_pend <= 1'b1;
              if (&count) state <= FLUSH;
            end
            // Natural wrap of an AWL-bit counter restarts the next frame at 0.
            count <= count + 1'b1;
          end
        end

        FLUSH: state <= KICK;

        KICK: begin
          start_pend <= 1'b1;
          tmo        <= '0;
          state      <= WAIT_ACK;
        end

        WAIT_ACK: begin
          if (i_RAM_BLOCK) begin
            state <= WAIT_REL;
          end else begin
            tmo <= tmo + 1'b1;
            if (tmo == TW'(ACK_TIMEOUT - 1)) begin
              err   <= 1'b1;
              state <= KICK;
            end
          end
        end

        WAIT_REL: if (!i_RAM_BLOCK) state <= FILL;

        default: state <= FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_fft_iter_sample_loader.sv
// Directed bench for fft_iter_sample_loader. Two instances share all inputs:
// u_dut uses bit-reversed addressing, u_dut_nr natural-order addressing.
module tb_fft_iter_sample_loader;

  localparam int IWL = 32;
  localparam int AWL = 5;
  localparam int N   = 32;

  logic           CLK = 1'b0;
  logic           RST;
  logic           EN;
  logic [IWL-1:0] i_DATA;
  logic           i_VALID;
  logic           i_RAM_BLOCK;

  logic           o_READY, o_RAM_Wr, o_START, o_ERR;
  logic [IWL-1:0] o_A_DATA, o_B_DATA, o_A_ADDR, o_B_ADDR;
  logic           nr_READY, nr_RAM_Wr, nr_START, nr_ERR;
  logic [IWL-1:0] nr_A_DATA, nr_B_DATA, nr_A_ADDR, nr_B_ADDR;

  fft_iter_sample_loader #(.IWL(IWL), .AWL(AWL), .BIT_REV(1), .ACK_TIMEOUT(15)) u_dut (
    .CLK(CLK), .RST(RST), .EN(EN), .i_DATA(i_DATA), .i_VALID(i_VALID),
    .o_READY(o_READY), .o_A_DATA(o_A_DATA), .o_B_DATA(o_B_DATA),
    .o_A_ADDR(o_A_ADDR), .o_B_ADDR(o_B_ADDR), .o_RAM_Wr(o_RAM_Wr),
    .o_START(o_START), .i_RAM_BLOCK(i_RAM_BLOCK), .o_ERR(o_ERR)
  );

  fft_iter_sample_loader #(.IWL(IWL), .AWL(AWL), .BIT_REV(0), .ACK_TIMEOUT(15)) u_dut_nr (
    .CLK(CLK), .RST(RST), .EN(EN), .i_DATA(i_DATA), .i_VALID(i_VALID),
    .o_READY(nr_READY), .o_A_DATA(nr_A_DATA), .o_B_DATA(nr_B_DATA),
    .o_A_ADDR(nr_A_ADDR), .o_B_ADDR(nr_B_ADDR), .o_RAM_Wr(nr_RAM_Wr),
    .o_START(nr_START), .i_RAM_BLOCK(i_RAM_BLOCK), .o_ERR(nr_ERR)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [IWL-1:0] a;
    logic [IWL-1:0] b;
    logic [IWL-1:0] aa;
    logic [IWL-1:0] ba;
    int             cyc;
  } wr_t;

  wr_t wr_q[$];
  wr_t wr_nr_q[$];
  int  cyc      = 0;
  int  n_start  = 0;
  int  n_checks = 0;
  int  n_pass   = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  // Write/START monitor, sampled on the falling edge.
  always @(negedge CLK) begin
    if (o_RAM_Wr)  wr_q.push_back('{o_A_DATA, o_B_DATA, o_A_ADDR, o_B_ADDR, cyc});
    if (nr_RAM_Wr) wr_nr_q.push_back('{nr_A_DATA, nr_B_DATA, nr_A_ADDR, nr_B_ADDR, cyc});
    if (o_START)   n_start <= n_start + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b1; EN = 1'b1; i_VALID = 1'b0; i_DATA = '0; i_RAM_BLOCK = 1'b0;
    tick(2);
    RST = 1'b0;
  endtask

  // Feed n samples base, base+1, ...; toggle drops i_VALID every other cycle.
  task automatic stream(input logic [31:0] base, input int n, input bit toggle);
    int  sent  = 0;
    int  guard = 0;
    bit  v     = 1'b1;
    bit  acc;
    while (sent < n && guard < 2000) begin
      i_DATA  = base + sent;
      i_VALID = v;
      @(negedge CLK);
      acc = i_VALID && o_READY;
      tick(1);
      if (acc) sent++;
      if (toggle) v = ~v;
      guard++;
    end
    i_VALID = 1'b0;
    if (sent != n) check("stream_done", sent, n);
  endtask

  task automatic wait_start(output int c);
    bit ok = 1'b0;
    c = -1;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge CLK);
      if (o_START) begin ok = 1'b1; c = cyc; end
    end
    tick(1);
    if (!ok) check("start_seen", 32'd0, 32'd1);
  endtask

  int base_w, base_nr, base_s, c1, c2, n_rdy, n_wr;

  initial begin
    // Reset state.
    do_reset();
    RST = 1'b1;
    @(negedge CLK);
    check("rst_ready", o_READY, 1);
    check("rst_wr", o_RAM_Wr, 0);
    check("rst_start", o_START, 0);
    check("rst_err", o_ERR, 0);
    check("rst_a_data", o_A_DATA, 0);
    check("rst_b_addr", o_B_ADDR, 0);
    tick(1);
    RST = 1'b0;

    // Full back-to-back frame, bit-reversed addresses.
    base_w = wr_q.size(); base_s = n_start;
    stream(32'h0, N, 1'b0);
    wait_start(c1);
    check("f1_nwr", wr_q.size() - base_w, 16);
    check("f1_w0_a", wr_q[base_w].a, 32'h0);
    check("f1_w0_b", wr_q[base_w].b, 32'h1);
    check("f1_w0_aa", wr_q[base_w].aa, 0);
    check("f1_w0_ba", wr_q[base_w].ba, 16);
    check("f1_w1_aa", wr_q[base_w+1].aa, 8);
    check("f1_w1_ba", wr_q[base_w+1].ba, 24);
    check("f1_w15_a", wr_q[base_w+15].a, 32'h1E);
    check("f1_w15_b", wr_q[base_w+15].b, 32'h1F);
    check("f1_w15_aa", wr_q[base_w+15].aa, 15);
    check("f1_w15_ba", wr_q[base_w+15].ba, 31);
    check("f1_start_lat", c1 - wr_q[base_w+15].cyc, 2);
    check("f1_nstart", n_start - base_s, 1);

    // Core blocks the RAM for 100 cycles with the stream pushing.
    i_RAM_BLOCK = 1'b1; i_VALID = 1'b1; i_DATA = 32'hDEAD;
    base_w = wr_q.size(); n_rdy = 0;
    repeat (100) begin
      @(negedge CLK);
      if (o_READY) n_rdy++;
      tick(1);
    end
    check("blk_ready", n_rdy, 0);
    check("blk_nwr", wr_q.size() - base_w, 0);
    i_RAM_BLOCK = 1'b0; i_VALID = 1'b0;
    base_w = wr_q.size();
    stream(32'h100, N, 1'b0);
    check("f2_w0_a", wr_q[base_w].a, 32'h100);
    check("f2_w0_b", wr_q[base_w].b, 32'h101);
    check("f2_w0_aa", wr_q[base_w].aa, 0);
    check("f2_w0_ba", wr_q[base_w].ba, 16);

    // No acknowledge: timeout raises o_ERR and re-issues START.
    wait_start(c1);
    check("to_err_before", o_ERR, 0);
    wait_start(c2);
    check("to_gap", c2 - c1, 16);
    check("to_err_after", o_ERR, 1);
    i_RAM_BLOCK = 1'b1;
    base_s = n_start;
    tick(30);
    check("to_wait_rel", n_start - base_s, 0);
    i_RAM_BLOCK = 1'b0;
    tick(1);
    @(negedge CLK);
    check("to_fill_ready", o_READY, 1);
    check("to_err_sticky", o_ERR, 1);
    tick(1);

    // Toggled valid, natural addressing.
    do_reset();
    check("rst_clears_err", o_ERR, 0);
    base_nr = wr_nr_q.size();
    stream(32'h200, N, 1'b1);
    wait_start(c1);
    check("tg_nwr", wr_nr_q.size() - base_nr, 16);
    for (int k = 0; k < 16; k += 5) begin
      check($sformatf("tg_w%0d_aa", k), wr_nr_q[base_nr+k].aa, 2*k);
      check($sformatf("tg_w%0d_ba", k), wr_nr_q[base_nr+k].ba, 2*k+1);
      check($sformatf("tg_w%0d_a", k),  wr_nr_q[base_nr+k].a, 32'h200 + 2*k);
      check($sformatf("tg_w%0d_b", k),  wr_nr_q[base_nr+k].b, 32'h201 + 2*k);
    end

    // Reset mid-frame discards the partial frame.
    do_reset();
    stream(32'h300, 9, 1'b0);
    RST = 1'b1;
    tick(2);
    RST = 1'b0;
    base_w = wr_q.size(); base_s = n_start;
    stream(32'h400, N, 1'b0);
    tick(6);
    check("mr_w0_a", wr_q[base_w].a, 32'h400);
    check("mr_w0_b", wr_q[base_w].b, 32'h401);
    check("mr_w0_aa", wr_q[base_w].aa, 0);
    check("mr_w0_ba", wr_q[base_w].ba, 16);
    check("mr_nwr", wr_q.size() - base_w, 16);
    check("mr_nstart", n_start - base_s, 1);

    // EN stall on the cycle a write is due.
    do_reset();
    base_w = wr_q.size(); base_s = n_start;
    stream(32'h500, 2, 1'b0);
    EN = 1'b0;
    n_wr = 0; n_rdy = 0;
    repeat (5) begin
      @(negedge CLK);
      if (o_RAM_Wr) n_wr++;
      if (o_READY) n_rdy++;
      tick(1);
    end
    check("en_no_wr", n_wr, 0);
    check("en_no_ready", n_rdy, 0);
    EN = 1'b1;
    tick(5);
    check("en_nwr", wr_q.size() - base_w, 1);
    check("en_w_a", wr_q[base_w].a, 32'h500);
    check("en_w_b", wr_q[base_w].b, 32'h501);
    check("en_w_aa", wr_q[base_w].aa, 0);
    check("en_w_ba", wr_q[base_w].ba, 16);
    check("en_nstart", n_start - base_s, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
